imem_fetch: RTL
===============

Name: imem_fetch

Overview:
- Instruction-memory responder on the fetch side of the datapath: consumes the 32-bit byte address driven by the program counter register and returns the addressed instruction word one cycle later.
- Also provides a word-serial program-load port (valid/ready) so a host or testbench can fill the memory at run time.
- While loading, it raises Stall so the core holds its PC.
- Sits between the PC register and the decode stage.

Parameters:
- DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (default 1024 words = 4 KiB).
- NOP_INSTR, 32'h0000_0000, word driven on Instr whenever no valid fetch is presented (MIPS sll $0,$0,0).

Ports:
- Clk  in  1  system clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- PC  in  32  byte address of the instruction to fetch.
- Instr  out  32  registered instruction word.
- InstrValid  out  1  Instr holds a legitimate fetch result this cycle.
- Misalign  out  1  registered; PC[1:0] != 0 on the fetch that produced the current Instr.
- OutOfRange  out  1  registered; PC[31:DEPTH_LOG2+2] != 0 on that fetch.
- Stall  out  1  core must hold PC and not consume Instr.
- LoadEn  in  1  level; high requests or continues program-load mode.
- LoadValid  in  1  LoadData is valid this cycle.
- LoadData  in  32  instruction word to write.
- LoadReady  out  1  block accepts LoadData this cycle.
- LoadCount  out  DEPTH_LOG2+1  words written in the current or most recent load session.

Behaviour:
- Reset (sync, active-high) values:
  - State RUN.
  - Instr = NOP_INSTR; InstrValid, Misalign, OutOfRange, Stall, LoadReady = 0; LoadCount = 0.
  - Memory array contents are NOT reset.
- States: RUN, LOAD, FLUSH.
  - RUN -> LOAD when LoadEn = 1. On that edge LoadCount clears to 0.
  - LOAD -> FLUSH when LoadEn = 0.
  - FLUSH -> RUN unconditionally after 1 cycle.
- Fetch in RUN:
  - Word index = PC[DEPTH_LOG2+1:2].
  - Registered read, latency 1: PC sampled at edge N gives Instr valid after edge N.
  - On each edge in RUN: InstrValid <= 1; Misalign <= (PC[1:0] != 0); OutOfRange <= (upper bits != 0).
  - If either fault condition holds, Instr <= NOP_INSTR; otherwise Instr <= mem[index].
  - Faults still assert InstrValid = 1; the core decides the trap.
  - Misalign and OutOfRange may both be 1.
- Stall = 1 in LOAD and FLUSH (combinational from state), 0 in RUN.
- Outside RUN, on every edge: Instr <= NOP_INSTR; InstrValid, Misalign, OutOfRange <= 0.
- Load handshake:
  - LoadReady = (state == LOAD) && (LoadCount < 2**DEPTH_LOG2), combinational.
  - Transfer occurs when LoadValid && LoadReady at a rising edge: mem[LoadCount] <= LoadData; LoadCount <= LoadCount + 1.
  - The transfer completes even if LoadEn falls in the same cycle.
- Boundary conditions:
  - Full: LoadCount saturates at 2**DEPTH_LOG2; LoadReady drops; extra LoadValid is ignored and nothing is overwritten.
  - RUN cycle with LoadEn = 1 and LoadValid = 1: no write (LoadReady = 0 in RUN). The first write is possible on the following cycle.
  - Empty load (LoadEn pulses with no valid): LoadCount = 0; memory unchanged.
  - LoadCount holds its value through FLUSH and RUN until the next load session or Reset.
  - Reset mid-load: session abandoned; state RUN; LoadCount = 0. Words already written remain in memory.
  - Address wrap: no wrap; any PC with nonzero upper bits flags OutOfRange.
- First fetch after FLUSH uses the PC presented in the first RUN cycle, so InstrValid rises one cycle after Stall falls.

Decomposition:
- Shared package holds:
  - State encoding constants: RUN = 2'd0, LOAD = 2'd1, FLUSH = 2'd2.
  - NOP_INSTR constant (32'h0), so the decoder can reuse it.
  - Word-address helper constant WORD_SHIFT = 2.
- One natural sub-module: imem_ram, a single-port synchronous-write / registered-read word RAM (DEPTH_LOG2 address bits, 32 data bits).
  - Its address is muxed between LoadCount (LOAD) and the PC index (RUN).
  - FSM, handshake and fault logic stay in imem_fetch.

Test Plan:
- Reset: hold Reset 2 cycles with PC = 32'h8 -> Instr = 0, InstrValid = 0, Stall = 0, LoadReady = 0, LoadCount = 0.
- Load then run: LoadEn = 1, send 32'h2008_0005, 32'h2009_0003, 32'h0109_5020, 32'hAC0A_0000 back-to-back, drop LoadEn.
  - Expect LoadCount = 4 and Stall high through FLUSH.
  - Then drive PC = 0, 4, 8, 12 -> Instr matches each word one cycle later, InstrValid = 1.
- Misalign: PC = 32'h0000_0006 in RUN -> next cycle Instr = 0, Misalign = 1, OutOfRange = 0, InstrValid = 1.
- Out of range (DEPTH_LOG2 = 10): PC = 32'h0000_1000 -> Instr = 0, OutOfRange = 1.
  - PC = 32'h0000_0FFC -> word 1023 returned, no fault.
- Full: DEPTH_LOG2 = 2, stream 6 words with LoadValid held high.
  - LoadReady falls after the 4th transfer; LoadCount = 4.
  - Words 5–6 are discarded; mem[0] still holds the first word.
- Reset mid-load: after 2 of 4 writes, assert Reset 1 cycle.
  - Expect state RUN, LoadCount = 0, Stall = 0.
  - PC = 0 and PC = 4 still return the two words already written.

Source files
------------

// File: rtl/imem_fetch_pkg.sv
// imem_fetch_pkg: shared state encoding and constants for the instruction-memory fetch block
package imem_fetch_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, LOAD = 2'd1, FLUSH = 2'd2} state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int WORD_SHIFT = 2;
endpackage

// File: rtl/imem_fetch_if.sv
// imem_fetch_if: fetch port toward the PC/decode stages plus the word-serial program-load port
interface imem_fetch_if #(parameter int DEPTH_LOG2 = 10);
  logic [31:0] PC;
  logic [31:0] Instr;
  logic InstrValid;
  logic Misalign;
  logic OutOfRange;
  logic Stall;
  logic LoadEn;
  logic LoadValid;
  logic [31:0] LoadData;
  logic LoadReady;
  logic [DEPTH_LOG2:0] LoadCount;
  modport master (
    output PC, LoadEn, LoadValid, LoadData,
    input Instr, InstrValid, Misalign, OutOfRange, Stall, LoadReady, LoadCount
  );
  modport slave (
    input PC, LoadEn, LoadValid, LoadData,
    output Instr, InstrValid, Misalign, OutOfRange, Stall, LoadReady, LoadCount
  );
endinterface

// File: rtl/imem_ram.sv
// imem_ram: single-port word RAM, synchronous write and registered read
module imem_ram #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  logic [31:0] mem [1 << DEPTH_LOG2];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/imem_fetch.sv
// imem_fetch: instruction-memory responder with registered fetch and a stalling program-load mode
module imem_fetch
  import imem_fetch_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] NOP_INSTR  = imem_fetch_pkg::NOP_INSTR
) (
  input logic         Clk,
  input logic         Reset,
  imem_fetch_if.slave bus
);
  state_t state, state_nxt;
  logic xfer, run;
  logic [31:0] rdata;
  logic [DEPTH_LOG2-1:0] addr;
  always_ff @(posedge Clk) state <= Reset ? RUN : state_nxt;
  always_comb begin
    state_nxt = state == RUN  ? (bus.LoadEn ? LOAD : RUN) :
                state == LOAD ? (bus.LoadEn ? LOAD : FLUSH) : RUN;
  end
  assign run           = state == RUN;
  assign bus.Stall     = !run;
  // LoadCount saturates exactly at the depth, so its top bit means full
  assign bus.LoadReady = state == LOAD && !bus.LoadCount[DEPTH_LOG2];
  assign xfer          = bus.LoadValid && bus.LoadReady && !Reset;
  always_ff @(posedge Clk) begin
    if (Reset || (run && bus.LoadEn)) bus.LoadCount <= '0;
    else if (xfer) bus.LoadCount <= bus.LoadCount + 1'b1;
  end
  always_ff @(posedge Clk) begin
    bus.InstrValid <= !Reset && run;
    bus.Misalign   <= !Reset && run && |bus.PC[1:0];
    bus.OutOfRange <= !Reset && run && |bus.PC[31:DEPTH_LOG2+WORD_SHIFT];
  end
  assign addr = state == LOAD ? bus.LoadCount[DEPTH_LOG2-1:0]
                              : bus.PC[DEPTH_LOG2+WORD_SHIFT-1:WORD_SHIFT];
  imem_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk  (Clk),
    .we   (xfer),
    .addr (addr),
    .wdata(bus.LoadData),
    .rdata(rdata)
  );
  assign bus.Instr = bus.InstrValid && !bus.Misalign && !bus.OutOfRange ? rdata : NOP_INSTR;
endmodule
